// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: per-operand forward selects from an in-flight tag pipeline plus load-use stall.
// Optional FWD_HAZARD_STATS_EN adds saturating stall_cycles / fwd_events counters.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ex_valid,
  input  logic [REG_ADDR_W-1:0]         ex_rd,
  input  logic                          ex_reg_write,
  input  logic                          ex_is_load,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic                          flush,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          stall
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   fwd_events
`endif
);
  logic [FWD_DEPTH:1] t_live, t_ld;
  logic [REG_ADDR_W-1:0] t_rd [1:FWD_DEPTH];
  logic ex_live;
  logic [REG_ADDR_W-1:0] ex_s, id_s;
  logic h;
  assign ex_live = ex_valid & ex_reg_write & ~flush & (ex_rd != '0);
  always_ff @(posedge clk) begin
    for (int k = FWD_DEPTH; k > 1; k--) begin
      t_live[k] <= t_live[k-1];
      t_rd[k] <= t_rd[k-1];
      t_ld[k] <= t_ld[k-1];
    end
    t_live[1] <= ex_live;
    t_rd[1] <= ex_rd;
    t_ld[1] <= ex_is_load;
    if (!rst_n) t_live <= '0;
  end
  // Scanning oldest to youngest lets the youngest matching producer overwrite older ones.
  always_comb begin
    fwd_sel = '0;
    stall = 1'b0;
    ex_s = '0;
    id_s = '0;
    h = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      ex_s = ex_src[j*REG_ADDR_W +: REG_ADDR_W];
      id_s = id_src[j*REG_ADDR_W +: REG_ADDR_W];
      h = 1'b0;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (t_live[k] && t_rd[k] == ex_s) fwd_sel[j*SEL_W +: SEL_W] = SEL_W'(k);
        if (t_live[k] && t_rd[k] == id_s) h = t_ld[k] && (k + 1 < LOAD_STAGE);
      end
      if (ex_live && ex_rd == id_s) h = ex_is_load && (LOAD_STAGE > 1);
      stall = stall | (id_valid && id_s != '0 && h);
    end
    if (!rst_n) begin
      fwd_sel = '0;
      stall = 1'b0;
    end
  end
`ifdef FWD_HAZARD_STATS_EN
  localparam int NW = $clog2(NUM_SRC + 1);
  logic [NW-1:0] n_fwd;
  logic [32:0] ev_sum;
  always_comb begin
    n_fwd = '0;
    for (int j = 0; j < NUM_SRC; j++)
      n_fwd = n_fwd + ((fwd_sel[j*SEL_W +: SEL_W] != '0) ? NW'(1) : NW'(0));
    ev_sum = {1'b0, fwd_events} + 33'(n_fwd);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      fwd_events <= '0;
    end else begin
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      fwd_events <= ev_sum[32] ? '1 : ev_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: scoreboard bench for the default build and a deep (4-stage, load at 3) variant.
module tb_fwd_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n, ex_valid, ex_reg_write, ex_is_load, id_valid, flush;
  logic [4:0] ex_rd;
  logic [9:0] ex_src, id_src;
  logic [3:0] sel_a;
  logic [5:0] sel_b;
  logic stall_a, stall_b;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fwd_hazard_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .ex_src(ex_src), .id_valid(id_valid), .id_src(id_src), .flush(flush),
    .fwd_sel(sel_a), .stall(stall_a)
  );
  fwd_hazard_ctrl #(.FWD_DEPTH(4), .LOAD_STAGE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .ex_src(ex_src), .id_valid(id_valid), .id_src(id_src), .flush(flush),
    .fwd_sel(sel_b), .stall(stall_b)
  );
  typedef struct packed {
    logic rn, v, wr, ld, fl;
    logic [4:0] rd, es0, es1;
    logic idv;
    logic [4:0] is0, is1;
    logic [2:0] s0, s1;
    logic st;
  } row_t;
  row_t sb[$];
  function automatic row_t r(input int rn, v, wr, ld, fl, rd, es0, es1, idv, is0, is1, s0, s1, st);
    row_t x;
    x.rn = rn[0]; x.v = v[0]; x.wr = wr[0]; x.ld = ld[0]; x.fl = fl[0];
    x.rd = rd[4:0]; x.es0 = es0[4:0]; x.es1 = es1[4:0];
    x.idv = idv[0]; x.is0 = is0[4:0]; x.is1 = is1[4:0];
    x.s0 = s0[2:0]; x.s1 = s1[2:0]; x.st = st[0];
    return x;
  endfunction
  task automatic apply(input row_t x);
    rst_n = x.rn; ex_valid = x.v; ex_reg_write = x.wr; ex_is_load = x.ld; flush = x.fl;
    ex_rd = x.rd; ex_src = {x.es1, x.es0}; id_valid = x.idv; id_src = {x.is1, x.is0};
  endtask
  task automatic test_reset();
    row_t e;
    row_t t[2];
    t = '{r(0, 1,1,1,0, 3, 3,3, 1, 3,3, 0,0,0),
          r(1, 0,0,0,0, 0, 3,3, 0, 0,0, 0,0,0)};
    foreach (t[i]) begin
      apply(t[i]); sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (sel_a !== {e.s1[1:0], e.s0[1:0]} || stall_a !== e.st) begin
        errors++;
        $display("FAIL reset[%0d] got sel=%h stall=%b want sel=%h stall=%b", i, sel_a, stall_a, {e.s1[1:0], e.s0[1:0]}, e.st);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_alu_fwd();
    row_t e;
    row_t t[4];
    t = '{r(1, 1,1,0,0, 3, 0,0, 0, 0,0, 0,0,0),
          r(1, 0,0,0,0, 0, 3,0, 0, 0,0, 1,0,0),
          r(1, 0,0,0,0, 0, 3,3, 0, 0,0, 2,2,0),
          r(1, 0,0,0,0, 0, 3,3, 0, 0,0, 0,0,0)};
    foreach (t[i]) begin
      apply(t[i]); sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (sel_a !== {e.s1[1:0], e.s0[1:0]} || stall_a !== e.st) begin
        errors++;
        $display("FAIL alu_fwd[%0d] got sel=%h stall=%b want sel=%h stall=%b", i, sel_a, stall_a, {e.s1[1:0], e.s0[1:0]}, e.st);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_youngest();
    row_t e;
    row_t t[4];
    t = '{r(1, 1,1,0,0, 3, 0,0, 0, 0,0, 0,0,0),
          r(1, 1,1,0,0, 3, 0,3, 0, 0,0, 0,1,0),
          r(1, 0,0,0,0, 0, 0,3, 0, 0,0, 0,1,0),
          r(1, 0,0,0,0, 0, 0,3, 0, 0,0, 0,2,0)};
    foreach (t[i]) begin
      apply(t[i]); sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (sel_a !== {e.s1[1:0], e.s0[1:0]} || stall_a !== e.st) begin
        errors++;
        $display("FAIL youngest[%0d] got sel=%h stall=%b want sel=%h stall=%b", i, sel_a, stall_a, {e.s1[1:0], e.s0[1:0]}, e.st);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_load_use();
    row_t e;
    row_t t[3];
    t = '{r(1, 1,1,1,0, 5, 0,0, 1, 5,0, 0,0,1),
          r(1, 0,0,0,0, 0, 0,0, 1, 5,0, 0,0,0),
          r(1, 1,1,0,0, 6, 5,0, 1, 6,0, 2,0,0)};
    foreach (t[i]) begin
      apply(t[i]); sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (sel_a !== {e.s1[1:0], e.s0[1:0]} || stall_a !== e.st) begin
        errors++;
        $display("FAIL load_use[%0d] got sel=%h stall=%b want sel=%h stall=%b", i, sel_a, stall_a, {e.s1[1:0], e.s0[1:0]}, e.st);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_zero_flush();
    row_t e;
    row_t t[5];
    t = '{r(1, 1,1,0,0, 0, 0,0, 0, 0,0, 0,0,0),
          r(1, 0,0,0,0, 0, 0,0, 1, 0,0, 0,0,0),
          r(1, 1,1,1,1, 5, 0,0, 0, 0,0, 0,0,0),
          r(1, 0,0,0,0, 0, 5,0, 1, 5,0, 0,0,0),
          r(1, 0,0,0,0, 0, 5,5, 1, 0,5, 0,0,0)};
    foreach (t[i]) begin
      apply(t[i]); sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (sel_a !== {e.s1[1:0], e.s0[1:0]} || stall_a !== e.st) begin
        errors++;
        $display("FAIL zero_flush[%0d] got sel=%h stall=%b want sel=%h stall=%b", i, sel_a, stall_a, {e.s1[1:0], e.s0[1:0]}, e.st);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_deep_load();
    row_t e;
    row_t t[5];
    t = '{r(1, 0,0,0,0, 0, 0,0, 0, 0,0, 0,0,0),
          r(1, 1,1,1,0, 7, 0,0, 1, 0,7, 0,0,1),
          r(1, 0,0,0,0, 0, 0,0, 1, 0,7, 0,0,1),
          r(1, 0,0,0,0, 0, 0,0, 1, 0,7, 0,0,0),
          r(1, 1,1,0,0, 8, 0,7, 0, 0,0, 0,3,0)};
    foreach (t[i]) begin
      apply(t[i]); sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (sel_b !== {e.s1, e.s0} || stall_b !== e.st) begin
        errors++;
        $display("FAIL deep_load[%0d] got sel=%h stall=%b want sel=%h stall=%b", i, sel_b, stall_b, {e.s1, e.s0}, e.st);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_back_to_back_reset();
    row_t e;
    row_t t[3];
    t = '{r(1, 1,1,1,0, 4, 0,0, 0, 0,0, 0,0,0),
          r(0, 0,0,0,0, 0, 4,4, 1, 4,4, 0,0,0),
          r(1, 0,0,0,0, 0, 4,4, 1, 4,4, 0,0,0)};
    foreach (t[i]) begin
      apply(t[i]); sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (sel_a !== {e.s1[1:0], e.s0[1:0]} || stall_a !== e.st) begin
        errors++;
        $display("FAIL mid_reset[%0d] got sel=%h stall=%b want sel=%h stall=%b", i, sel_a, stall_a, {e.s1[1:0], e.s0[1:0]}, e.st);
      end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    apply(r(0, 0,0,0,0, 0, 0,0, 0, 0,0, 0,0,0));
    @(posedge clk); #1;
    test_reset();
    test_alu_fwd();
    test_youngest();
    test_load_use();
    test_zero_flush();
    test_deep_load();
    test_back_to_back_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
